// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: backend load/store unit.
// Takes one memory request from the EXU/LSU register and runs one valid/ready
// bus transaction for it. Results go to the LSU/WBU register as a one-cycle
// resp_valid pulse. The result carries aligned, extended load data and
// exception flags.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus wait after
// TIMEOUT_CYCLES idle bus cycles with an access fault.
module lsu_mem_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            lsu_busy,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            exc_load_misalign,
    output logic            exc_store_misalign,
    output logic            exc_access_fault,
    output logic            bus_valid,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ready,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic            mem_req;
    logic            misalign;
    logic            accept;
    logic            complete;
    logic            timeout_hit;

    logic            bus_valid_q;
    logic            bus_we_q;
    logic [XLEN-1:0] bus_addr_q;
    logic [3:0]      bus_be_q;
    logic [XLEN-1:0] bus_wdata_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            exc_load_misalign_q;
    logic            exc_store_misalign_q;

    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    assign mem_req  = req_load | req_store;
    // Sizes 2 and 3 are both words, so req_size[1] covers both.
    assign misalign = ((req_size == 2'd1) & req_addr[0]) |
                      (req_size[1] & (req_addr[1:0] != 2'd0));

    // Per-lane byte enable and write-data replication for the incoming request.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be_calc[gi] = req_size[1] ? 1'b1 :
                                 (req_size == 2'd1) ? (LANE[1] == req_addr[1]) :
                                 (LANE == req_addr[1:0]);
            assign wdata_rep[gi*8 +: 8] = req_size[1] ? req_wdata[gi*8 +: 8] :
                                          (req_size == 2'd1) ? req_wdata[(gi%2)*8 +: 8] :
                                          req_wdata[7:0];
        end
    endgenerate

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] tmo_cnt_q;
    logic          exc_access_fault_q;

    assign timeout_hit = (state_q == S_WAIT) && !bus_ready &&
                         (tmo_cnt_q == CW'(TIMEOUT_CYCLES));

    // Wait counter: cleared on WAIT entry, counts WAIT cycles without bus_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q          <= '0;
            exc_access_fault_q <= 1'b0;
        end else begin
            exc_access_fault_q <= timeout_hit;
            if (accept) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_WAIT && !bus_ready && !timeout_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign exc_access_fault = exc_access_fault_q;
`else
    assign timeout_hit      = 1'b0;
    assign exc_access_fault = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mem_req && !misalign) state_d = S_WAIT;
            S_WAIT:  if (bus_ready || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: stall and the accept/complete strobes for the datapath.
    // Busy drops in the completion cycle so upstream advances exactly once.
    always_comb begin
        lsu_busy = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req && !misalign) begin
                    lsu_busy = !rst;
                    accept   = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus_ready) begin
                    complete = 1'b1;
                end else if (!timeout_hit) begin
                    lsu_busy = !rst;
                end
            end
            default: ;
        endcase
    end

    // Load alignment and extension from the held request attributes.
    always_comb begin
        shifted  = bus_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0:    load_ext = {{24{shifted[7]  & ~uns_q}}, shifted[7:0]};
            2'd1:    load_ext = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Bus request registers and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid_q          <= 1'b0;
            bus_we_q             <= 1'b0;
            bus_addr_q           <= '0;
            bus_be_q             <= 4'd0;
            bus_wdata_q          <= '0;
            off_q                <= 2'd0;
            size_q               <= 2'd0;
            uns_q                <= 1'b0;
            resp_valid_q         <= 1'b0;
            resp_rdata_q         <= '0;
            exc_load_misalign_q  <= 1'b0;
            exc_store_misalign_q <= 1'b0;
        end else begin
            resp_valid_q         <= 1'b0;
            resp_rdata_q         <= '0;
            exc_load_misalign_q  <= 1'b0;
            exc_store_misalign_q <= 1'b0;

            if (accept) begin
                bus_valid_q <= 1'b1;
                bus_we_q    <= req_store;
                bus_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                bus_be_q    <= be_calc;
                bus_wdata_q <= wdata_rep;
                off_q       <= req_addr[1:0];
                size_q      <= req_size;
                uns_q       <= req_unsigned;
            end

            // Misaligned requests never touch the bus; they answer next cycle.
            if (state_q == S_IDLE && mem_req && misalign) begin
                resp_valid_q         <= 1'b1;
                exc_load_misalign_q  <= req_load;
                exc_store_misalign_q <= req_store;
            end

            if (complete) begin
                bus_valid_q  <= 1'b0;
                resp_valid_q <= 1'b1;
                resp_rdata_q <= bus_we_q ? '0 : load_ext;
            end else if (timeout_hit) begin
                bus_valid_q  <= 1'b0;
                resp_valid_q <= 1'b1;
            end
        end
    end

    assign bus_valid          = bus_valid_q;
    assign bus_we             = bus_we_q;
    assign bus_addr           = bus_addr_q;
    assign bus_be             = bus_be_q;
    assign bus_wdata          = bus_wdata_q;
    assign resp_valid         = resp_valid_q;
    assign resp_rdata         = resp_rdata_q;
    assign exc_load_misalign  = exc_load_misalign_q;
    assign exc_store_misalign = exc_store_misalign_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Testbench for lsu_mem_unit: directed scenarios plus randomized requests
// checked against a byte-level memory model and transaction rules.
module tb_lsu_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_load, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        lsu_busy, resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_load_misalign, exc_store_misalign, exc_access_fault;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_mem_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_load(req_load), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_busy(lsu_busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .exc_load_misalign(exc_load_misalign), .exc_store_misalign(exc_store_misalign),
        .exc_access_fault(exc_access_fault),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    int tests = 0;
    int fails = 0;
    int bv_cnt = 0;
    int txn = 0;

    logic [31:0] mem [0:63];

    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [3:0]  last_be;
    int          busy_cycles, stable_cnt;

    // Count cycles in which a bus request is outstanding.
    always @(negedge clk) if (bus_valid === 1'b1) bv_cnt <= bv_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = 4'd0;
        for (int k = 0; k < nbytes(sz); k++) be[int'(a[1:0]) + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_rep(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nbytes(sz))*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input bit uns);
        longint unsigned v = 0;
        int nb = nbytes(sz);
        for (int k = 0; k < nb; k++)
            v = v | (longint'(word[(int'(a[1:0]) + k)*8 +: 8]) << (8*k));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        return v[31:0];
    endfunction

    // One request; entered and left at a negedge. The request stays driven on
    // return so the caller can chain the next request in the same cycle.
    task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input int waits);
        int idx = int'(a[7:2]);
        logic [31:0] expd, first_wd;
        req_load = !st; req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; bus_ready = 1'b0;
        #1;
        txn++;
        if (is_misaligned(sz, a)) begin
            chk("misalign_busy", lsu_busy, 0);
            chk("misalign_nobus", bus_valid, 0);
            tick;
            chk("misalign_resp_valid", resp_valid, 1);
            chk("misalign_exc_load", exc_load_misalign, !st);
            chk("misalign_exc_store", exc_store_misalign, st);
            chk("misalign_rdata", resp_rdata, 0);
            chk("misalign_nobus2", bus_valid, 0);
            last_rdata = resp_rdata;
            $display("[TB] txn %0d %s size=%0d addr=%h misaligned", txn, st ? "ST" : "LD", sz, a);
            return;
        end
        busy_cycles = 0; stable_cnt = 0; first_wd = 32'd0;
        chk("accept_busy", lsu_busy, 1);
        chk("accept_bus_idle", bus_valid, 0);
        if (lsu_busy) busy_cycles++;
        tick;
        for (int w = 0; w <= waits; w++) begin
            chk("wait_bus_valid", bus_valid, 1);
            chk("wait_bus_we", bus_we, st);
            chk("wait_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("wait_bus_be", bus_be, exp_be(sz, a));
            if (st) chk("wait_bus_wdata", bus_wdata, exp_rep(sz, wd));
            chk("wait_no_resp", resp_valid, 0);
            if (w == 0) begin
                last_be = bus_be; last_addr = bus_addr; last_wdata = bus_wdata;
                first_wd = bus_wdata;
            end
            if (bus_valid && bus_wdata == first_wd) stable_cnt++;
            bus_ready = (w == waits);
            bus_rdata = (bus_ready && !st) ? mem[idx] : $urandom;
            #1;
            chk("wait_busy", lsu_busy, (w != waits));
            if (lsu_busy) busy_cycles++;
            tick;
        end
        bus_ready = 1'b0;
        bus_rdata = $urandom;
        if (st) begin
            for (int k = 0; k < nbytes(sz); k++)
                mem[idx][(int'(a[1:0]) + k)*8 +: 8] = wd[k*8 +: 8];
            expd = 32'd0;
        end else begin
            expd = exp_load(mem[idx], a, sz, uns);
        end
        chk("resp_bus_dropped", bus_valid, 0);
        chk("resp_valid", resp_valid, 1);
        chk("resp_rdata", resp_rdata, expd);
        chk("resp_exc_load", exc_load_misalign, 0);
        chk("resp_exc_store", exc_store_misalign, 0);
        chk("resp_exc_fault", exc_access_fault, 0);
        last_rdata = resp_rdata;
        $display("[TB] txn %0d %s size=%0d uns=%0d addr=%h waits=%0d rdata=%h exp=%h",
                 txn, st ? "ST" : "LD", sz, uns, a, waits, resp_rdata, expd);
    endtask

    task automatic idle(input int n);
        req_load = 1'b0; req_store = 1'b0; bus_ready = 1'b0;
        repeat (n) begin
            #1;
            chk("idle_busy", lsu_busy, 0);
            tick;
        end
    endtask

    initial begin
        int b0;
        rst = 1'b1; req_load = 0; req_store = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; bus_ready = 0; bus_rdata = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        @(negedge clk);
        tick; tick;
        chk("reset_bus_valid", bus_valid, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_busy", lsu_busy, 0);
        chk("reset_bus_be", bus_be, 0);
        chk("reset_bus_addr", bus_addr, 0);
        chk("reset_rdata", resp_rdata, 0);
        rst = 1'b0;
        tick;

        // LB / LBU from the top byte of a word.
        mem[0] = 32'h80FF_FF00;
        do_req(0, 2'd0, 0, 32'h1003, 32'h0, 0);
        chk("lb_rdata_lit", last_rdata, 32'hFFFF_FF80);
        chk("lb_be_lit", last_be, 4'b1000);
        chk("lb_addr_lit", last_addr, 32'h1000);
        chk("lb_busy_cycles", busy_cycles, 1);
        do_req(0, 2'd0, 1, 32'h1003, 32'h0, 0);
        chk("lbu_rdata_lit", last_rdata, 32'h0000_0080);
        idle(1);

        // SH with three wait cycles.
        do_req(1, 2'd1, 0, 32'h2002, 32'h1234_ABCD, 3);
        chk("sh_be_lit", last_be, 4'b1100);
        chk("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
        chk("sh_busy_cycles", busy_cycles, 4);
        chk("sh_wdata_stable", stable_cnt, 4);
        idle(1);

        // Misaligned word accesses.
        b0 = bv_cnt;
        do_req(0, 2'd2, 0, 32'h3001, 32'h0, 0);
        do_req(1, 2'd2, 0, 32'h3002, 32'h5555_AAAA, 0);
        idle(1);
        chk("misalign_no_bus_cycles", bv_cnt - b0, 0);

        // Back-to-back word loads on a zero-wait bus.
        mem[4] = 32'h1111_2222;
        mem[5] = 32'h3333_4444;
        b0 = bv_cnt;
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
        chk("b2b_first_lit", last_rdata, 32'h1111_2222);
        do_req(0, 2'd2, 0, 32'h14, 32'h0, 0);
        chk("b2b_second_lit", last_rdata, 32'h3333_4444);
        idle(1);
        chk("b2b_bus_cycles", bv_cnt - b0, 2);

        // Reset while waiting on the bus.
        req_load = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; bus_ready = 1'b0;
        tick;
        chk("rstwait_bus_valid_before", bus_valid, 1);
        rst = 1'b1; req_load = 1'b0;
        tick;
        chk("rstwait_bus_valid", bus_valid, 0);
        chk("rstwait_busy", lsu_busy, 0);
        chk("rstwait_no_resp", resp_valid, 0);
        rst = 1'b0;
        tick;
        chk("rstwait_no_resp2", resp_valid, 0);
        $display("[TB] reset in WAIT done");
        do_req(0, 2'd2, 0, 32'h40, 32'h0, 1);
        idle(1);

`ifdef LSU_TIMEOUT_EN
        // Bus never answers: four busy WAIT cycles, then the fault.
        req_load = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h20; bus_ready = 1'b0;
        tick;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("tmo_busy", lsu_busy, 1);
            chk("tmo_bus_valid", bus_valid, 1);
            tick;
        end
        #1;
        chk("tmo_busy_drop", lsu_busy, 0);
        req_load = 1'b0;
        tick;
        chk("tmo_bus_dropped", bus_valid, 0);
        chk("tmo_resp_valid", resp_valid, 1);
        chk("tmo_fault", exc_access_fault, 1);
        chk("tmo_rdata", resp_rdata, 0);
        $display("[TB] timeout fault checked");
        idle(1);
`endif

        // Randomized traffic against the memory model.
        repeat (150) begin
            do_req(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                   32'($urandom % 256), $urandom, int'($urandom % 4));
            if ($urandom % 3 == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Load/store unit in the backend LSU stage. Consumes the memory request produced by the execute stage and held in the EXU/LSU pipeline register.
- Runs one bus transaction per request over a valid/ready handshake.
- Returns aligned, sign- or zero-extended load data plus exception flags to the LSU/WBU pipeline register.
- Drives the backend stall through lsu_busy.

Parameters:
- XLEN, 32: data and address width (only 32 is supported).
- TIMEOUT_CYCLES, 255: bus wait cycles before access fault (used only when LSU_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_load  in  1  memory read request
- req_store  in  1  memory write request (never asserted together with req_load)
- req_size  in  2  0=byte, 1=half, 2=word (3 is treated as word)
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- lsu_busy  out  1  stall: the upstream request register must hold
- resp_valid  out  1  one-cycle pulse: the previous request has completed
- resp_rdata  out  XLEN  extended load data (0 for stores and faults)
- exc_load_misalign  out  1  valid with resp_valid
- exc_store_misalign  out  1  valid with resp_valid
- exc_access_fault  out  1  valid with resp_valid
- bus_valid  out  1  bus request
- bus_we  out  1  write enable
- bus_addr  out  XLEN  word-aligned address (addr[1:0]=0)
- bus_be  out  4  byte enables
- bus_wdata  out  XLEN  lane-replicated write data
- bus_ready  in  1  transaction complete (read data valid)
- bus_rdata  in  XLEN  read word

Behaviour:
- Reset: all outputs 0; state IDLE.
  - Reset in WAIT drops bus_valid in the next cycle.
  - No resp_valid is produced for the aborted request.
- States and transitions:
  - IDLE -> WAIT on an aligned request.
  - WAIT -> IDLE on bus_ready (or on timeout).
- mem_req = req_load | req_store.
- Misaligned request: half with addr[0]=1, or word with addr[1:0]!=0.
- lsu_busy (combinational):
  - Asserted in IDLE when mem_req and the request is aligned.
  - Asserted in WAIT while !bus_ready (and no timeout).
  - Deasserted in the completion cycle, so upstream advances on that edge and the request is never accepted twice.
- Aligned request accepted in IDLE (cycle T):
  - Bus fields are registered at T.
  - At T+1: bus_valid=1 and state=WAIT.
  - bus_addr, bus_we, bus_be and bus_wdata stay stable until bus_ready.
- bus_ready sampled in WAIT (earliest at T+1):
  - bus_valid=0 on the next edge.
  - Result is registered and resp_valid pulses in the following cycle (earliest T+2).
  - Result latency is therefore 2 cycles minimum for a zero-wait bus.
- Misaligned request in IDLE:
  - No bus access and no busy.
  - Next cycle: resp_valid=1 with exc_load_misalign or exc_store_misalign set, resp_rdata=0.
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
- Write data: byte replicated 4x, half replicated 2x, word as-is.
- Load data:
  - Shift bus_rdata right by addr[1:0]*8.
  - Take the low 8/16/32 bits.
  - Sign-extend unless req_unsigned.
- A request presented in the completion cycle of the previous one is evaluated from IDLE in the next cycle (back-to-back, one idle cycle between bus_valid pulses).
- resp_valid pulse and new acceptance may occur in the same cycle.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on WAIT entry and increments each WAIT cycle without bus_ready.
  - On reaching TIMEOUT_CYCLES, lsu_busy deasserts that cycle and the state returns to IDLE.
  - bus_valid drops next cycle; resp_valid pulses with exc_access_fault=1 and resp_rdata=0.
  - A bus_ready arriving in the timeout cycle wins: normal completion, no fault.
- Undefined: no counter; WAIT persists until bus_ready; exc_access_fault is constant 0.

Test Plan:
- LB, addr=0x1003, bus_rdata=0x80FF_FF00, ready at first WAIT cycle:
  - bus_be=4'b1000, bus_addr=0x1000.
  - busy high 1 cycle; resp_rdata=0xFFFF_FF80 two cycles after request.
  - LBU under the same stimulus returns 0x0000_0080.
- SH, addr=0x2002, wdata=0x1234_ABCD, ready after 3 wait cycles:
  - bus_we=1, bus_be=4'b1100, bus_wdata=0xABCD_ABCD held stable 4 cycles.
  - busy high 4 cycles; resp_valid once, no exceptions.
- LW addr=0x3001: no bus_valid, busy never high, resp_valid next cycle with exc_load_misalign=1. SW addr=0x3002 gives exc_store_misalign=1.
- Back-to-back LW 0x10 then LW 0x14, zero-wait bus:
  - Two distinct bus transactions, each address issued exactly once.
  - Two resp_valid pulses with the correct data in order.
- Reset asserted in WAIT: bus_valid=0 and busy=0 the next cycle, no resp_valid. A subsequent LW completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, bus_ready held 0:
  - busy drops after 4 WAIT cycles.
  - resp_valid with exc_access_fault=1, bus_valid deasserted.
